fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the single-port, combinational-read instruction memory for the dual-issue front end.
//  Owns the PC, fetches one 32-bit word per cycle into a small in-order instruction queue,
//  and presents up to two {pc, inst} pairs per cycle to decode.
//  Handles branch/jump redirect (flush + new PC) and stops fetching at the end of instruction memory.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; byte address, word aligned
//  IMEM_WORDS  64             instruction memory depth in 32-bit words; fetch limit = IMEM_WORDS*4
//  DEPTH       4              instruction queue entries; power of two, >= 2
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   synchronous, active-high reset
//  imem_addr       out  32  byte address to instruction memory (= pc_q); memory uses addr[31:2]
//  imem_rdata      in   32  instruction word returned combinationally for imem_addr
//  fetch_en        in   1   1 = fetching allowed; 0 = hold PC, no push (dequeue still works)
//  redirect_valid  in   1   taken branch/jump from execute; highest priority
//  redirect_pc     in   32  new fetch address; bits [1:0] forced to 0
//  out0_valid      out  1   slot 0 holds oldest queued instruction
//  out0_pc         out  32  PC of slot 0
//  out0_inst       out  32  instruction of slot 0
//  out1_valid      out  1   slot 1 holds second-oldest instruction
//  out1_pc         out  32  PC of slot 1
//  out1_inst       out  32  instruction of slot 1
//  out0_ready      in   1   decode consumes slot 0 this cycle
//  out1_ready      in   1   decode consumes slot 1; honoured only with out0_ready (in-order)
//  fetch_done      out  1   pc_q >= IMEM_WORDS*4; no further pushes until redirect/reset
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, queue count=0, rd/wr pointers=0.
//   out0_valid=out1_valid=0; out*_pc/inst=0 when invalid; fetch_done per RESET_PC.
//  imem_addr = pc_q combinationally; no memory latency; instruction captured same cycle.
//  Push: when fetch_en & !redirect_valid & !fetch_done & count<DEPTH (registered count), enqueue
//   {pc_q, imem_rdata} and pc_q <= pc_q+4. A full queue blocks the push even if decode pops that cycle.
//  Outputs: out0 = entry at rd_ptr, valid iff count>=1; out1 = entry at rd_ptr+1 (mod DEPTH), valid iff count>=2.
//  Pop count per cycle: pop = (out0_valid&out0_ready) ? 1+(out1_valid&out1_ready) : 0.
//  Push + pop in the same cycle: count <= count + push - pop; rd_ptr += pop; wr_ptr += push (mod DEPTH).
//  Redirect (redirect_valid=1): queue flushed (count, rd_ptr, wr_ptr <= 0); same-cycle pops and push discarded;
//   pc_q <= {redirect_pc[31:2],2'b00}. Outputs invalid the next cycle; the first new instruction is visible 2 cycles after redirect.
//  Redirect while fetch_en=0 still updates the PC. Redirect to an address >= IMEM_WORDS*4 sets fetch_done (no wrap).
//  PC increment never wraps; after the last word fetch_done=1 and the queue drains normally.
//  Reset asserted mid-operation overrides redirect and all traffic; state is restored exactly as at reset.
//  Arithmetic: pc 32-bit unsigned; count width $clog2(DEPTH)+1; pointers $clog2(DEPTH) bits, natural wrap.
// STRUCTURE
//  Shared package fetch_pkg: XLEN=32, INST_W=32, fetch_entry_t {pc[31:0], inst[31:0]}, NOP_INST=32'h0000_0013.
//  Sub-module fetch_queue: circular buffer, 1 push / 0-2 pops / flush, exposes head and head+1 entries and count.
//  Top level holds pc_q, push/redirect/fetch_done logic, and the memory address mux.
// TESTING
//  Reset, fetch_en=1, readies=0 -> PCs 0,4,8,C queued; count=4, push stops; imem_addr holds 0x10.
//  Full queue, out0_ready=out1_ready=1 for one cycle -> outputs PC 0x8/0xC next cycle;
//   push resumes the following cycle with pc 0x10.
//  out0_ready=0, out1_ready=1 with both valid -> no pop; count unchanged.
//  Redirect to 0x23 with 3 entries queued plus readies high -> next cycle count=0, pc_q=0x20;
//   out0 valid with pc 0x20 one cycle later.
//  Free-run with readies=1 from reset, IMEM_WORDS=64 -> last pushed pc=0xFC; fetch_done=1 with pc_q=0x100;
//   the queue drains to empty; redirect to 0x0 clears fetch_done.
//  Reset asserted together with redirect_valid mid-stream -> pc_q=RESET_PC, queue empty, outputs invalid next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order circular instruction queue: one push, zero to two pops, and a
// flush per cycle. Exposes the two oldest entries and the occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic [1:0]               pop_cnt,
  output fetch_entry_t             head0,
  output fetch_entry_t             head1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;

  // Storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      wr_ptr <= wr_ptr + PW'(push);
      count  <= count + CW'(push) - CW'(pop_cnt);
    end
  end

  assign rd_nxt = rd_ptr + PW'(1);
  assign head0  = mem[rd_ptr];
  assign head1  = mem[rd_nxt];
endmodule

// File: rtl/fetch_controller.sv
// Dual-issue fetch sequencer: owns the PC, streams one word per cycle from a
// combinational instruction memory into fetch_queue, and handles redirects.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out0_valid,
  output logic [XLEN-1:0]   out0_pc,
  output logic [INST_W-1:0] out0_inst,
  output logic              out1_valid,
  output logic [XLEN-1:0]   out1_pc,
  output logic [INST_W-1:0] out1_inst,
  input  logic              out0_ready,
  input  logic              out1_ready,
  output logic              fetch_done
);
  localparam int              CW          = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] FETCH_LIMIT = XLEN'(IMEM_WORDS * 4);

  logic [XLEN-1:0] pc_q, redirect_aligned;
  logic [CW-1:0]   count;
  logic            q_full, push, pop0, pop1;
  logic [1:0]      pop_cnt;
  fetch_entry_t    head0, head1, push_entry;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign fetch_done       = pc_q >= FETCH_LIMIT;
  assign q_full           = count >= CW'(DEPTH);

  // Fullness uses the registered count, so a same-cycle pop never frees a slot.
  assign push = fetch_en & ~redirect_valid & ~fetch_done & ~q_full;

  assign out0_valid = count != '0;
  assign out1_valid = count >= CW'(2);
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = pop0 & out1_valid & out1_ready;
  assign pop_cnt    = 2'(pop0) + 2'(pop1);

  assign push_entry = '{pc: pc_q, inst: imem_rdata};

  always_ff @(posedge clk) begin
    if (reset)               pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= redirect_aligned;
    else if (push)           pc_q <= pc_q + XLEN'(4);
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop_cnt    (pop_cnt),
    .head0      (head0),
    .head1      (head1),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign out0_pc   = out0_valid ? head0.pc   : '0;
  assign out0_inst = out0_valid ? head0.inst : '0;
  assign out1_pc   = out1_valid ? head1.pc   : '0;
  assign out1_inst = out1_valid ? head1.inst : '0;
endmodule

// File: tb/tb_fetch_controller.sv
// Randomized and directed stimulus for fetch_controller against a queue-based reference model.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int          IW    = 64;
  localparam int          D     = 4;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] LIMIT = 32'd256;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, out0_ready, out1_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic        out0_valid, out1_valid, fetch_done;
  logic [31:0] out0_pc, out0_inst, out1_pc, out1_inst;

  logic [31:0]  tmem [IW];
  fetch_entry_t mq [$];
  logic [31:0]  mpc;
  int           ncmp = 0;
  int           nerr = 0;

  always #5 clk = ~clk;

  always_comb imem_rdata = (imem_addr < LIMIT) ? tmem[imem_addr[7:2]] : NOP_INST;

  fetch_controller #(.RESET_PC(RPC), .IMEM_WORDS(IW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .out0_ready(out0_ready), .out1_ready(out1_ready), .fetch_done(fetch_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("out0_valid", 32'(out0_valid), 32'(n >= 1));
    chk("out1_valid", 32'(out1_valid), 32'(n >= 2));
    chk("out0_pc",   out0_pc,   (n >= 1) ? mq[0].pc   : 32'h0);
    chk("out0_inst", out0_inst, (n >= 1) ? mq[0].inst : 32'h0);
    chk("out1_pc",   out1_pc,   (n >= 2) ? mq[1].pc   : 32'h0);
    chk("out1_inst", out1_inst, (n >= 2) ? mq[1].inst : 32'h0);
    chk("imem_addr", imem_addr, mpc);
    chk("fetch_done", 32'(fetch_done), 32'(mpc >= LIMIT));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic rst, input logic fe, input logic rv,
                      input logic [31:0] rpc, input logic r0, input logic r1);
    int  npop;
    bit  pu;
    reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc;
    out0_ready = r0; out1_ready = r1;
    if (rst) begin
      mq.delete();
      mpc = RPC;
    end else if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      pu   = fe && (mpc < LIMIT) && (mq.size() < D);
      npop = 0;
      if (r0 && mq.size() >= 1) npop = (r1 && mq.size() >= 2) ? 2 : 1;
      repeat (npop) void'(mq.pop_front());
      if (pu) begin
        mq.push_back('{pc: mpc, inst: tmem[mpc[7:2]]});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < IW; i++) tmem[i] = $urandom;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    mpc = RPC;

    // Reset, then fill the queue with decode stalled.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    // Double pop from a full queue; push resumes a cycle later.
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Slot 1 ready alone must not pop.
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // Three entries queued, redirect to an unaligned address with readies high.
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 32'h23, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Redirect with fetch disabled, and beyond the end of memory.
    step(0, 0, 1, 32'h44, 0, 0);
    step(0, 1, 1, 32'h104, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    // Reset together with redirect mid-stream.
    step(0, 1, 1, 32'h10, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h80, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      logic rst, fe, rv, r0, r1;
      logic [31:0] rpc;
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      fe  = ($urandom_range(0, 3) != 0);
      r0  = 1'($urandom_range(0, 1));
      r1  = 1'($urandom_range(0, 1));
      rpc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(240, 300))
                                        : 32'($urandom_range(0, 255));
      step(rst, fe, rv, rpc, r0, r1);
    end

    // Free-run to the end of memory, drain, then redirect back to 0.
    step(1, 0, 0, 0, 0, 0);
    repeat (90) step(0, 1, 0, 0, 1, 1);
    step(0, 1, 1, 32'h0, 1, 1);
    repeat (4) step(0, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
